// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : main control FSM of the multicycle RV32I core.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ImmSrc,
  output logic        MemByte,
  output logic        Illegal,
  output logic [31:0] InstrRet
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER,
    S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_ret_q, instr_ret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr_bits;

  assign opcode            = Instr[6:0];
  assign funct3            = Instr[14:12];
  assign funct7_5          = Instr[30];
  assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      instr_ret_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      instr_ret_q <= instr_ret_d;
    end
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (opcode)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI:    ImmSrc = 3'b111;
      default:   ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    instr_ret_d = instr_ret_q;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUControl  = 3'b000;
    ResultSrc   = 2'b00;
    MemByte     = 1'b0;
    Illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target is computed here into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD:   state_d = (funct3 == 3'b010 || funct3 == 3'b100) ? S_MEMADR : S_TRAP;
          OP_STORE:  state_d = (funct3 == 3'b010 || funct3 == 3'b000) ? S_MEMADR : S_TRAP;
          OP_RTYPE:  state_d = (funct3 == 3'b000 || funct3 == 3'b111 ||
                                funct3 == 3'b110 || funct3 == 3'b010) ? S_EXECUTER : S_TRAP;
          OP_ITYPE:  state_d = (funct3 == 3'b000) ? S_EXECUTEI : S_TRAP;
          OP_BRANCH: state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_TRAP;
          OP_JAL:    state_d = S_JAL;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemByte = (funct3 == 3'b100);
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        MemByte  = (funct3 == 3'b000);
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        case (funct3)
          3'b000:  ALUControl = funct7_5 ? 3'b001 : 3'b000;
          3'b111:  ALUControl = 3'b010;
          3'b110:  ALUControl = 3'b011;
          3'b010:  ALUControl = 3'b101;
          default: ALUControl = 3'b000;
        endcase
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = (funct3 == 3'b000) ? Zero : !Zero;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        Illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase

    // Every path that lands back in FETCH from a non-FETCH state retires one instruction.
    if (state_q != S_FETCH && state_d == S_FETCH) instr_ret_d = instr_ret_q + 32'd1;

    if (!rst_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign InstrRet = instr_ret_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : scoreboard bench for the multicycle control FSM.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instr = 32'd0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b1;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, MemByte, Illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ALUControl, ImmSrc;
  logic [31:0] InstrRet;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .MemByte(MemByte), .Illegal(Illegal),
    .InstrRet(InstrRet)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                ALUControl, ResultSrc, ImmSrc, MemByte, Illegal};

  typedef struct {
    logic [31:0] instr;
    logic        mr;
    logic        z;
    logic [18:0] ctl;
    logic [31:0] ret;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ret_model = 32'd0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [18:0] mk(input logic pcw, input logic irw, input logic rw,
                                     input logic mw, input logic adr, input logic [1:0] sa,
                                     input logic [1:0] sbb, input logic [2:0] alu,
                                     input logic [1:0] rs, input logic [2:0] imm,
                                     input logic mb, input logic ill);
    return {pcw, irw, rw, mw, adr, sa, sbb, alu, rs, imm, mb, ill};
  endfunction

  function automatic logic [18:0] c_fetch(input logic mr, input logic [2:0] imm);
    return mk(mr, mr, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, imm, 0, 0);
  endfunction

  function automatic logic [18:0] c_decode(input logic [2:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00, imm, 0, 0);
  endfunction

  function automatic logic [18:0] c_aluwb(input logic [2:0] imm);
    return mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, imm, 0, 0);
  endfunction

  function automatic logic [18:0] c_memadr(input logic [2:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, imm, 0, 0);
  endfunction

  task automatic push(input logic [31:0] i, input logic mr, input logic z,
                      input logic [18:0] c, input string tag);
    exp_t e;
    e.instr = i; e.mr = mr; e.z = z; e.ctl = c; e.ret = ret_model; e.tag = tag;
    sb.push_back(e);
  endtask

  // Drives one cycle of stimulus from the scoreboard head and returns what the DUT shows.
  task automatic pop_cycle(output logic [18:0] o, output logic [18:0] x,
                           output logic [31:0] ro, output logic [31:0] rx, output string t);
    exp_t e;
    e = sb.pop_front();
    @(negedge clk);
    Instr = e.instr; MemReady = e.mr; Zero = e.z;
    #1;
    o = obs; x = e.ctl; ro = InstrRet; rx = e.ret; t = e.tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; MemReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks += 3;
    if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
    end
    if (InstrRet !== 32'd0) begin
      errors++; $display("FAIL reset_instrret: got %h expected 0", InstrRet);
    end
    if (ALUSrcB !== 2'b10) begin
      errors++; $display("FAIL reset_fetch_srcb: got %b expected 10", ALUSrcB);
    end
    rst_n = 1'b1; MemReady = 1'b0;
  endtask

  task automatic test_add();
    logic [18:0] o, x; logic [31:0] ro, rx; string t;
    logic [31:0] i = 32'h002081B3;
    push(i, 1, 0, c_fetch(1, 3'b000), "add.FETCH");
    push(i, 1, 0, c_decode(3'b000), "add.DECODE");
    push(i, 1, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0), "add.EXECR");
    push(i, 1, 0, c_aluwb(3'b000), "add.ALUWB");
    ret_model++;
    while (sb.size() > 0) begin
      pop_cycle(o, x, ro, rx, t);
      checks += 2;
      if (o !== x) begin errors++; $display("FAIL %s ctl: got %h expected %h", t, o, x); end
      if (ro !== rx) begin errors++; $display("FAIL %s InstrRet: got %h expected %h", t, ro, rx); end
    end
  endtask

  task automatic test_alu_ops();
    logic [18:0] o, x; logic [31:0] ro, rx; string t;
    logic [31:0] ops [4] = '{32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3};
    logic [2:0]  alu [4] = '{3'b001, 3'b010, 3'b011, 3'b101};
    logic [31:0] addi = 32'h00500093;
    for (int k = 0; k < 4; k++) begin
      push(ops[k], 1, 0, c_fetch(1, 3'b000), $sformatf("rop%0d.FETCH", k));
      push(ops[k], 1, 0, c_decode(3'b000), $sformatf("rop%0d.DECODE", k));
      push(ops[k], 1, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, alu[k], 2'b00, 3'b000, 0, 0),
           $sformatf("rop%0d.EXECR", k));
      push(ops[k], 1, 0, c_aluwb(3'b000), $sformatf("rop%0d.ALUWB", k));
      ret_model++;
    end
    push(addi, 1, 0, c_fetch(1, 3'b000), "addi.FETCH");
    push(addi, 1, 0, c_decode(3'b000), "addi.DECODE");
    push(addi, 1, 0, mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 0, 0), "addi.EXECI");
    push(addi, 1, 0, c_aluwb(3'b000), "addi.ALUWB");
    ret_model++;
    while (sb.size() > 0) begin
      pop_cycle(o, x, ro, rx, t);
      checks += 2;
      if (o !== x) begin errors++; $display("FAIL %s ctl: got %h expected %h", t, o, x); end
      if (ro !== rx) begin errors++; $display("FAIL %s InstrRet: got %h expected %h", t, ro, rx); end
    end
  endtask

  task automatic test_load_wait();
    logic [18:0] o, x; logic [31:0] ro, rx; string t;
    logic [31:0] lw = 32'h0000A183;
    logic [31:0] lbu = 32'h0000C183;
    push(lw, 1, 0, c_fetch(1, 3'b000), "lw.FETCH");
    push(lw, 1, 0, c_decode(3'b000), "lw.DECODE");
    push(lw, 1, 0, c_memadr(3'b000), "lw.MEMADR");
    for (int k = 0; k < 3; k++)
      push(lw, 0, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0), "lw.MEMREAD_wait");
    push(lw, 1, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0), "lw.MEMREAD");
    push(lw, 1, 0, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 0, 0), "lw.MEMWB");
    ret_model++;
    push(lbu, 1, 0, c_fetch(1, 3'b000), "lbu.FETCH");
    push(lbu, 1, 0, c_decode(3'b000), "lbu.DECODE");
    push(lbu, 1, 0, c_memadr(3'b000), "lbu.MEMADR");
    push(lbu, 1, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1, 0), "lbu.MEMREAD");
    push(lbu, 1, 0, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 0, 0), "lbu.MEMWB");
    ret_model++;
    while (sb.size() > 0) begin
      pop_cycle(o, x, ro, rx, t);
      checks += 2;
      if (o !== x) begin errors++; $display("FAIL %s ctl: got %h expected %h", t, o, x); end
      if (ro !== rx) begin errors++; $display("FAIL %s InstrRet: got %h expected %h", t, ro, rx); end
    end
  endtask

  task automatic test_branch();
    logic [18:0] o, x; logic [31:0] ro, rx; string t;
    logic [31:0] ins [3] = '{32'h00208463, 32'h00208463, 32'h00209463};
    logic        zs  [3] = '{1'b1, 1'b0, 1'b0};
    logic        pcw [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      push(ins[k], 1, zs[k], c_fetch(1, 3'b010), $sformatf("br%0d.FETCH", k));
      push(ins[k], 1, zs[k], c_decode(3'b010), $sformatf("br%0d.DECODE", k));
      push(ins[k], 1, zs[k], mk(pcw[k], 0, 0, 0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 3'b010, 0, 0),
           $sformatf("br%0d.BRANCH", k));
      ret_model++;
    end
    while (sb.size() > 0) begin
      pop_cycle(o, x, ro, rx, t);
      checks += 2;
      if (o !== x) begin errors++; $display("FAIL %s ctl: got %h expected %h", t, o, x); end
      if (ro !== rx) begin errors++; $display("FAIL %s InstrRet: got %h expected %h", t, ro, rx); end
    end
  endtask

  task automatic test_store_wait();
    logic [18:0] o, x; logic [31:0] ro, rx; string t;
    logic [31:0] i = 32'h00208223;
    push(i, 1, 0, c_fetch(1, 3'b001), "sb.FETCH");
    push(i, 1, 0, c_decode(3'b001), "sb.DECODE");
    push(i, 1, 0, c_memadr(3'b001), "sb.MEMADR");
    push(i, 0, 0, mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001, 1, 0), "sb.MEMWRITE_w1");
    push(i, 0, 0, mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001, 1, 0), "sb.MEMWRITE_w2");
    push(i, 1, 0, mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001, 1, 0), "sb.MEMWRITE");
    ret_model++;
    push(i, 0, 0, c_fetch(0, 3'b001), "sb.next_FETCH");
    while (sb.size() > 0) begin
      pop_cycle(o, x, ro, rx, t);
      checks += 2;
      if (o !== x) begin errors++; $display("FAIL %s ctl: got %h expected %h", t, o, x); end
      if (ro !== rx) begin errors++; $display("FAIL %s InstrRet: got %h expected %h", t, ro, rx); end
    end
  endtask

  task automatic test_trap();
    logic [18:0] o, x; logic [31:0] ro, rx; string t;
    logic [31:0] i = 32'h0000007F;
    push(i, 1, 0, c_fetch(1, 3'b000), "trap.FETCH");
    push(i, 1, 0, c_decode(3'b000), "trap.DECODE");
    for (int k = 0; k < 20; k++)
      push(i, 1, k[0], mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 1), "trap.TRAP");
    while (sb.size() > 0) begin
      pop_cycle(o, x, ro, rx, t);
      checks += 2;
      if (o !== x) begin errors++; $display("FAIL %s ctl: got %h expected %h", t, o, x); end
      if (ro !== rx) begin errors++; $display("FAIL %s InstrRet: got %h expected %h", t, ro, rx); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; MemReady = 1'b0;
    ret_model = 32'd0;
    #1;
    checks += 2;
    if (obs !== c_fetch(0, 3'b000)) begin
      errors++; $display("FAIL trap_reset_state: got %h expected %h", obs, c_fetch(0, 3'b000));
    end
    if (InstrRet !== 32'd0) begin
      errors++; $display("FAIL trap_reset_instrret: got %h expected 0", InstrRet);
    end
  endtask

  task automatic test_jal_lui();
    logic [18:0] o, x; logic [31:0] ro, rx; string t;
    logic [31:0] jal = 32'h008000EF;
    logic [31:0] lui = 32'h123452B7;
    dut.instr_ret_q = 32'hFFFFFFFE;
    ret_model = 32'hFFFFFFFE;
    push(jal, 0, 0, c_fetch(0, 3'b011), "jal.FETCH_wait");
    push(jal, 1, 0, c_fetch(1, 3'b011), "jal.FETCH");
    push(jal, 1, 0, c_decode(3'b011), "jal.DECODE");
    push(jal, 1, 0, mk(1, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 2'b00, 3'b011, 0, 0), "jal.JAL");
    push(jal, 1, 0, c_aluwb(3'b011), "jal.ALUWB");
    ret_model++;
    push(lui, 1, 0, c_fetch(1, 3'b111), "lui.FETCH");
    push(lui, 1, 0, c_decode(3'b111), "lui.DECODE");
    push(lui, 1, 0, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b11, 3'b111, 0, 0), "lui.LUI");
    ret_model++;
    push(lui, 0, 0, c_fetch(0, 3'b111), "lui.wrap_FETCH");
    while (sb.size() > 0) begin
      pop_cycle(o, x, ro, rx, t);
      checks += 2;
      if (o !== x) begin errors++; $display("FAIL %s ctl: got %h expected %h", t, o, x); end
      if (ro !== rx) begin errors++; $display("FAIL %s InstrRet: got %h expected %h", t, ro, rx); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_load_wait();
    test_branch();
    test_store_wait();
    test_trap();
    test_jal_lui();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I core: sequences fetch, decode, execute, memory and writeback over the shared ALU, register file, immediate extender and single memory port. Decodes the held instruction register into mux selects, write strobes, ALU operation and the immediate-format select for the sign extender. Stalls on a memory-ready handshake and traps on unsupported encodings.

## Interface
- No parameters.
- `clk`: in, 1. Rising-edge clock.
- `rst_n`: in, 1. Synchronous, active-low reset.
- `Instr`: in, 32. Instruction-register output; stable from DECODE to the end of the instruction.
- `Zero`: in, 1. ALU zero flag.
- `MemReady`: in, 1. Memory completes the current access this cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`: out, 1 each. Write strobes.
- `AdrSrc`: out, 1. Memory address select: 0 = PC, 1 = Result.
- `ALUSrcA`: out, 2. 00 = PC, 01 = OldPC, 10 = RegA.
- `ALUSrcB`: out, 2. 00 = RegB, 01 = ImmExt, 10 = constant 4.
- `ALUControl`: out, 3. 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ResultSrc`: out, 2. 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- `ImmSrc`: out, 3. 000 I-type, 001 S-type, 010 B-type, 011 J-type, 111 U-type.
- `MemByte`: out, 1. Byte access (lbu/sb); 0 = word.
- `Illegal`: out, 1. High while in TRAP.
- `InstrRet`: out, 32. Retired-instruction counter.

## Operation
- Supported instructions: lw/lbu (0000011, funct3 010/100), sw/sb (0100011, funct3 010/000), R-type add/sub/and/or/slt (0110011), addi (0010011, funct3 000), beq/bne (1100011, funct3 000/001), jal (1101111), lui (0110111). Any other opcode or funct3 combination is illegal: DECODE goes to TRAP.
- ImmSrc is decoded combinationally from the opcode in every state: load/addi 000, store 001, branch 010, jal 011, lui 111. Illegal opcodes give 000.
- States and actions. Every output not listed is 0.
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite and PCWrite equal MemReady. Stay while MemReady=0; otherwise go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target into ALUOut). Next state by opcode: MEMADR, EXECUTER, EXECUTEI, BRANCH, JAL, LUI, or TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Load goes to MEMREAD; store goes to MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00, MemByte per funct3. Wait for MemReady, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, MemByte per funct3. Hold until MemReady, then go to FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00. ALUControl from funct3/funct7[5]: 000/0 add, 000/1 sub, 111 and, 110 or, 010 slt. Go to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, add. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = Zero for beq, !Zero for bne. Go to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Go to ALUWB.
  - LUI: ResultSrc=11, RegWrite=1. Go to FETCH.
  - TRAP: all strobes 0, Illegal=1. Absorbing; only reset exits.
- InstrRet increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or LUI. It wraps from 0xFFFFFFFF to 0.

## Timing
- State and InstrRet are registered. All other outputs are combinational from state, Instr, Zero and MemReady.
- Reset: on a rising edge with rst_n=0, state becomes FETCH and InstrRet becomes 0. While rst_n=0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Reset mid-instruction (including a MEMWRITE wait) abandons the instruction with no further writes.
- Latency at zero wait states, counted in cycles from entering FETCH to re-entering FETCH:
  - lw/lbu: 5.
  - sw/sb, R-type, addi, jal: 4.
  - beq/bne, lui: 3.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Strobes are held stable throughout the wait.

## Test plan
- Reset, then MemReady=1 and Instr=add x3,x1,x2 (0x002081B3): states FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000 in EXECUTER; RegWrite=1 for exactly one cycle; InstrRet=1.
- lw (0x0000A183) with MemReady low for 3 cycles in MEMREAD: the instruction takes 8 cycles; AdrSrc=1 held during the wait; RegWrite only in MEMWB; ImmSrc=000.
- beq with Zero=1, then with Zero=0: PCWrite=1 and then 0 in BRANCH; ALUControl=001; ImmSrc=010; 3 cycles each.
- sb (funct3 000) with MemReady delayed 2 cycles: MemWrite=1 and MemByte=1 for 3 consecutive cycles, then FETCH; ImmSrc=001.
- Opcode 0x7F: enters TRAP from DECODE; Illegal=1 and all strobes 0 for 20 cycles; rst_n low for one edge returns to FETCH with InstrRet=0.
- jal then lui: jal has PCWrite in JAL and RegWrite in ALUWB, ImmSrc=011; lui has ResultSrc=11, ImmSrc=111, 3 cycles. InstrRet preloaded near 0xFFFFFFFF wraps to 0.
